alu_div_seq: RTL and testbench

Iterative RV32M divide sequencer that executes DIV/DIVU/REM/REMU by driving the shared 32-bit ALU one operation per cycle instead of instantiating a dedicated subtractor array.
- Sits beside the EX stage and requests ALU time from the ALU-sharing arbiter.
- Stalls whenever no grant is given.
- Returns a single registered result with a one-cycle done pulse.
- Handles sign fix-up, divide-by-zero and signed overflow per the RISC-V M-extension rules.

---
 rtl/alu_div_seq.sv | 175 +++++++++++++++++
 tb/tb_alu_div_seq.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_div_seq.sv
// Iterative RV32M divide sequencer (DIV/DIVU/REM/REMU) that borrows a shared 32-bit ALU
// one operation per granted cycle, using restoring division with sign fix-up.
package alu_div_pkg;
  typedef enum logic [3:0] {
    alu_add  = 4'd0,
    alu_sub  = 4'd1,
    alu_and  = 4'd2,
    alu_or   = 4'd3,
    alu_xor  = 4'd4,
    alu_sll  = 4'd5,
    alu_srl  = 4'd6,
    alu_sra  = 4'd7,
    alu_slt  = 4'd8,
    alu_sltu = 4'd9
  } alu_ops;
endpackage

module alu_div_seq
  import alu_div_pkg::*;
#(
  parameter int unsigned ITERS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  funct,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        ready,
  output logic        done,
  output logic [31:0] result,
  output logic        alu_req,
  input  logic        alu_gnt,
  output alu_ops      aluop,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_f
);

  typedef enum logic [2:0] {IDLE, PREP_A, PREP_B, ITER, FIX} state_t;

  state_t      state, state_next;
  logic        want_rem;
  logic        neg_a, neg_b;
  logic [31:0] qsrc;
  logic [31:0] dvs;
  logic [32:0] rem;
  logic [31:0] quo;
  logic [5:0]  cnt;
  logic        pend;
  logic [31:0] pend_val;

  logic [32:0] rs;
  logic        ge;
  logic [31:0] fix_val;
  logic        fix_neg;
  logic        div_zero, ovf, special;
  logic [31:0] special_val;

  assign rs      = {rem[31:0], qsrc[31]};
  assign ge      = rs >= {1'b0, dvs};
  assign fix_val = want_rem ? rem[31:0] : quo;
  assign fix_neg = want_rem ? neg_a : (neg_a ^ neg_b);

  // Zero divisor and signed overflow are answered without touching the ALU.
  assign div_zero    = (divisor == 32'd0);
  assign ovf         = ~funct[0] & (dividend == 32'h8000_0000) & (divisor == 32'hFFFF_FFFF);
  assign special     = div_zero | ovf;
  assign special_val = div_zero ? (funct[1] ? dividend : 32'hFFFF_FFFF)
                                : (funct[1] ? 32'd0 : 32'h8000_0000);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    alu_req    = 1'b0;
    aluop      = alu_add;
    alu_a      = 32'd0;
    alu_b      = 32'd0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start && !special) state_next = PREP_A;
      end
      PREP_A: begin
        alu_req = 1'b1;
        if (neg_a) begin aluop = alu_sub; alu_b = qsrc; end
        else       alu_a = qsrc;
        if (alu_gnt) state_next = PREP_B;
      end
      PREP_B: begin
        alu_req = 1'b1;
        if (neg_b) begin aluop = alu_sub; alu_b = dvs; end
        else       alu_a = dvs;
        if (alu_gnt) state_next = ITER;
      end
      ITER: begin
        alu_req = 1'b1;
        aluop   = alu_sub;
        alu_a   = rs[31:0];
        alu_b   = dvs;
        if (alu_gnt && cnt == 6'(ITERS - 1)) state_next = FIX;
      end
      FIX: begin
        alu_req = 1'b1;
        if (fix_neg) begin aluop = alu_sub; alu_b = fix_val; end
        else         alu_a = fix_val;
        if (alu_gnt) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      want_rem <= 1'b0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      qsrc     <= 32'd0;
      dvs      <= 32'd0;
      rem      <= 33'd0;
      quo      <= 32'd0;
      cnt      <= 6'd0;
      pend     <= 1'b0;
      pend_val <= 32'd0;
      done     <= 1'b0;
      result   <= 32'd0;
    end else begin
      done <= 1'b0;
      pend <= 1'b0;
      // Special-case answers are held one cycle so done lands one edge after start.
      if (pend) begin
        done   <= 1'b1;
        result <= pend_val;
      end
      case (state)
        IDLE: if (start) begin
          want_rem <= funct[1];
          neg_a    <= ~funct[0] & dividend[31];
          neg_b    <= ~funct[0] & divisor[31];
          qsrc     <= dividend;
          dvs      <= divisor;
          if (special) begin
            pend     <= 1'b1;
            pend_val <= special_val;
          end
        end
        PREP_A: if (alu_gnt) qsrc <= alu_f;
        PREP_B: if (alu_gnt) begin
          dvs <= alu_f;
          cnt <= 6'd0;
          rem <= 33'd0;
          quo <= 32'd0;
        end
        ITER: if (alu_gnt) begin
          // alu_f = Rs - |divisor| is exact whenever ge holds, since that difference fits in 32 bits.
          rem  <= ge ? {1'b0, alu_f} : rs;
          quo  <= {quo[30:0], ge};
          qsrc <= {qsrc[30:0], 1'b0};
          cnt  <= cnt + 6'd1;
        end
        FIX: if (alu_gnt) begin
          result <= alu_f;
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_div_seq.sv
// Self-checking bench for alu_div_seq: directed RV32M cases, random divides against an
// arithmetic reference, grant stalls, back-to-back starts and mid-operation reset.
module tb_alu_div_seq;
  import alu_div_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  funct = 2'b00;
  logic [31:0] dividend = 32'd0;
  logic [31:0] divisor = 32'd0;
  logic        alu_gnt = 1'b1;
  logic        ready, done, alu_req;
  logic [31:0] result, alu_a, alu_b, alu_f;
  alu_ops      aluop;

  int n_checks = 0;
  int n_fail = 0;
  bit [255:0] stall_at;

  typedef struct {
    logic [1:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
    int          c;
  } vec_t;

  vec_t dir_tbl[9] = '{
    '{2'b01, 32'd100,        32'd7,          32'd14,         35},
    '{2'b11, 32'd100,        32'd7,          32'd2,          35},
    '{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  35},
    '{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  35},
    '{2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1,          35},
    '{2'b00, 32'd5,          32'd0,          32'hFFFF_FFFF,  1},
    '{2'b11, 32'd5,          32'd0,          32'd5,          1},
    '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1},
    '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1}
  };

  always #5 clk = ~clk;

  // Shared ALU stand-in: combinational add/sub.
  always_comb alu_f = (aluop == alu_sub) ? (alu_a - alu_b) : (alu_a + alu_b);

  alu_div_seq dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .funct    (funct),
    .dividend (dividend),
    .divisor  (divisor),
    .ready    (ready),
    .done     (done),
    .result   (result),
    .alu_req  (alu_req),
    .alu_gnt  (alu_gnt),
    .aluop    (aluop),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_f    (alu_f)
  );

  function automatic bit is_special(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    return (b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] ref_div(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    if (b == 0) return f[1] ? a : 32'hFFFF_FFFF;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f[1] ? 32'd0 : 32'h8000_0000;
    sa = a;
    sb = b;
    case (f)
      2'b00:   return 32'(sa / sb);
      2'b01:   return a / b;
      2'b10:   return 32'(sa % sb);
      default: return a % b;
    endcase
  endfunction

  // Issues one divide and follows it to done, stalling the grant on chosen ALU cycles.
  task automatic run_div(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                         input int nstall, output int cyc, output logic [31:0] res,
                         output bit req_seen, output bit hold_ok, output bit stall_ok);
    int k, p, req_idx;
    logic [31:0] prev_res, a_s, b_s;
    alu_ops op_s;
    bit stalled;
    stall_at = '0;
    k = 0;
    while (k < nstall) begin
      p = $urandom_range(0, 34 + nstall - 1);
      if (!stall_at[p]) begin stall_at[p] = 1'b1; k++; end
    end
    @(negedge clk);
    start = 1'b1; funct = f; dividend = a; divisor = b; alu_gnt = 1'b1;
    prev_res = result;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0; req_idx = 0; req_seen = 0; hold_ok = 1; stall_ok = 1;
    while (!done && cyc < 200) begin
      if (result !== prev_res) hold_ok = 0;
      @(negedge clk);
      stalled = 0;
      if (alu_req) begin
        req_seen = 1;
        stalled = stall_at[req_idx[7:0]];
        req_idx++;
      end
      alu_gnt = !stalled;
      op_s = aluop; a_s = alu_a; b_s = alu_b;
      @(posedge clk); #1;
      cyc++;
      if (stalled && (aluop !== op_s || alu_a !== a_s || alu_b !== b_s || alu_req !== 1'b1)) stall_ok = 0;
    end
    alu_gnt = 1'b1;
    res = result;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (ready !== 1'b1)   begin n_fail++; $display("FAIL reset_ready: got %b expected 1", ready); end
    n_checks++; if (done !== 1'b0)    begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (result !== 32'd0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", result); end
    n_checks++; if (alu_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", alu_req); end
    n_checks++; if (aluop !== alu_add || alu_a !== 32'd0 || alu_b !== 32'd0) begin
      n_fail++; $display("FAIL reset_alu: got op=%0d a=%h b=%h expected op=0 a=0 b=0", aluop, alu_a, alu_b);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_directed();
    int cyc; logic [31:0] res; bit rq, hold, stl;
    for (int i = 0; i < 9; i++) begin
      run_div(dir_tbl[i].f, dir_tbl[i].a, dir_tbl[i].b, 0, cyc, res, rq, hold, stl);
      $display("directed %0d: funct=%b %h / %h -> %h after %0d cycles", i, dir_tbl[i].f, dir_tbl[i].a, dir_tbl[i].b, res, cyc);
      n_checks++; if (res !== dir_tbl[i].e) begin n_fail++; $display("FAIL directed_result[%0d]: got %h expected %h", i, res, dir_tbl[i].e); end
      n_checks++; if (cyc !== dir_tbl[i].c) begin n_fail++; $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, cyc, dir_tbl[i].c); end
      n_checks++; if (rq !== (dir_tbl[i].c != 1)) begin n_fail++; $display("FAIL directed_alu_req[%0d]: got %b expected %b", i, rq, dir_tbl[i].c != 1); end
      n_checks++; if (!hold) begin n_fail++; $display("FAIL directed_hold[%0d]: result changed before done", i); end
    end
  endtask

  task automatic test_stall();
    int cyc; logic [31:0] res; bit rq, hold, stl;
    run_div(2'b01, 32'hFFFF_FFFF, 32'd1, 10, cyc, res, rq, hold, stl);
    $display("stall: DIVU ffffffff / 1 -> %h after %0d cycles", res, cyc);
    n_checks++; if (res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL stall_result: got %h expected ffffffff", res); end
    n_checks++; if (cyc !== 45) begin n_fail++; $display("FAIL stall_latency: got %0d expected 45", cyc); end
    n_checks++; if (!stl) begin n_fail++; $display("FAIL stall_stable: ALU outputs changed during a stall (got 0 expected 1)"); end
  endtask

  task automatic test_random();
    int cyc, ns, ecyc; logic [31:0] res, a, b, e; logic [1:0] f; bit rq, hold, stl;
    for (int i = 0; i < 24; i++) begin
      f = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFF_FFFF;
        3:       b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      ns = $urandom_range(0, 4);
      e = ref_div(f, a, b);
      ecyc = is_special(f, a, b) ? 1 : 35 + ns;
      run_div(f, a, b, ns, cyc, res, rq, hold, stl);
      $display("random %0d: funct=%b %h / %h stalls=%0d -> %h after %0d cycles", i, f, a, b, ns, res, cyc);
      n_checks++; if (res !== e) begin n_fail++; $display("FAIL random_result[%0d]: got %h expected %h", i, res, e); end
      n_checks++; if (cyc !== ecyc) begin n_fail++; $display("FAIL random_latency[%0d]: got %0d expected %0d", i, cyc, ecyc); end
      n_checks++; if (!stl) begin n_fail++; $display("FAIL random_stall_stable[%0d]: got 0 expected 1", i); end
    end
  endtask

  task automatic test_back_to_back();
    int cyc; logic [31:0] res; bit rq, hold, stl;
    run_div(2'b01, 32'd1000, 32'd10, 0, cyc, res, rq, hold, stl);
    run_div(2'b11, 32'd1000, 32'd7, 0, cyc, res, rq, hold, stl);
    $display("back_to_back: REMU 1000 / 7 -> %h after %0d cycles", res, cyc);
    n_checks++; if (res !== 32'd6) begin n_fail++; $display("FAIL b2b_result: got %h expected 6", res); end
    n_checks++; if (cyc !== 35) begin n_fail++; $display("FAIL b2b_latency: got %0d expected 35", cyc); end
    n_checks++; if (!hold) begin n_fail++; $display("FAIL b2b_hold: result changed before done (expected held 64)"); end
    run_div(2'b00, 32'd5, 32'd0, 0, cyc, res, rq, hold, stl);
    run_div(2'b00, 32'd42, 32'hFFFF_FFFA, 0, cyc, res, rq, hold, stl);
    $display("back_to_back: DIV 42 / -6 -> %h after %0d cycles", res, cyc);
    n_checks++; if (res !== 32'hFFFF_FFF9) begin n_fail++; $display("FAIL b2b_special_then_div: got %h expected fffffff9", res); end
    n_checks++; if (cyc !== 35) begin n_fail++; $display("FAIL b2b_special_latency: got %0d expected 35", cyc); end
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b0 || result !== 32'hFFFF_FFF9) begin
      n_fail++; $display("FAIL done_pulse: got done=%b result=%h expected done=0 result=fffffff9", done, result);
    end
  endtask

  task automatic test_busy_start();
    int cyc;
    @(negedge clk);
    start = 1'b1; funct = 2'b01; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    repeat (5) begin @(posedge clk); #1; cyc++; end
    @(negedge clk);
    start = 1'b1; funct = 2'b00; dividend = 32'd1000; divisor = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; cyc++;
    while (!done && cyc < 200) begin @(posedge clk); #1; cyc++; end
    $display("busy_start: DIVU 100 / 7 with ignored start -> %h after %0d cycles", result, cyc);
    n_checks++; if (result !== 32'd14) begin n_fail++; $display("FAIL busy_start_result: got %h expected 14", result); end
    n_checks++; if (cyc !== 35) begin n_fail++; $display("FAIL busy_start_latency: got %0d expected 35", cyc); end
    @(posedge clk); #1;
    n_checks++; if (ready !== 1'b1 || alu_req !== 1'b0) begin
      n_fail++; $display("FAIL busy_start_idle: got ready=%b req=%b expected ready=1 req=0", ready, alu_req);
    end
  endtask

  task automatic test_reset_mid();
    int cyc; logic [31:0] res; bit rq, hold, stl, saw_done;
    @(negedge clk);
    start = 1'b1; funct = 2'b01; dividend = 32'h1234_5678; divisor = 32'h11;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (18) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    $display("reset_mid: rst asserted during iteration 16");
    n_checks++; if (ready !== 1'b1 || done !== 1'b0 || result !== 32'd0) begin
      n_fail++; $display("FAIL reset_mid_status: got ready=%b done=%b result=%h expected 1 0 0", ready, done, result);
    end
    n_checks++; if (alu_req !== 1'b0 || aluop !== alu_add || alu_a !== 32'd0 || alu_b !== 32'd0) begin
      n_fail++; $display("FAIL reset_mid_alu: got req=%b op=%0d a=%h b=%h expected 0 0 0 0", alu_req, aluop, alu_a, alu_b);
    end
    @(negedge clk);
    rst = 1'b1;
    saw_done = 0;
    repeat (40) begin @(posedge clk); #1; if (done || alu_req) saw_done = 1; end
    n_checks++; if (saw_done) begin n_fail++; $display("FAIL reset_mid_quiet: got activity after reset expected none"); end
    run_div(2'b01, 32'd9, 32'd3, 0, cyc, res, rq, hold, stl);
    $display("reset_mid: DIVU 9 / 3 -> %h after %0d cycles", res, cyc);
    n_checks++; if (res !== 32'd3) begin n_fail++; $display("FAIL reset_mid_next: got %h expected 3", res); end
    n_checks++; if (cyc !== 35) begin n_fail++; $display("FAIL reset_mid_latency: got %0d expected 35", cyc); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_random();
    test_back_to_back();
    test_busy_start();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
